// File: rtl/common.sv
// Shared scalar types used across the source-stage blocks.
package common;

  typedef logic [63:0] word_t;
  typedef logic        u1;

endpackage : common

// File: rtl/source_pkg.sv
// Sizing constants and request types for the source stage and its
// operand register file.
package source_pkg;

  import common::*;

  localparam int AREG_READ_PORTS = 8;   // 4 ALU, 2 MEM, 1 branch, 1 mult
  localparam int AREG_NUM        = 32;  // x0 hardwired to zero
  localparam int PREG_NUM        = 32;  // must be a power of two
  localparam int WB_PORTS        = 4;
  localparam int COMMIT_PORTS    = 4;   // lower index = older

  localparam int AREG_W = 5;
  localparam int PREG_W = $clog2(PREG_NUM);

  typedef logic [AREG_W-1:0] areg_addr_t;
  typedef logic [PREG_W-1:0] preg_addr_t;

  typedef struct packed {
    u1          valid;
    preg_addr_t pdst;
    word_t      data;
  } wb_req_t;

  typedef struct packed {
    u1          valid;
    preg_addr_t psrc;
    areg_addr_t dst;
  } commit_req_t;

endpackage : source_pkg

// File: rtl/regbank.sv
// Multi-read / multi-write register array. Writes landing on the same
// entry in one cycle resolve by port index (highest wins). Optionally
// forwards same-cycle write data to matching reads, and optionally
// hardwires entry 0 to zero.
module regbank #(
  parameter int DEPTH    = 32,
  parameter int WIDTH    = 64,
  parameter int N_READ   = 1,
  parameter int N_WRITE  = 1,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b0,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_WRITE-1:0] we,
  input  logic [AW-1:0]     waddr [N_WRITE],
  input  logic [WIDTH-1:0]  wdata [N_WRITE],
  input  logic [AW-1:0]     raddr [N_READ],
  output logic [WIDTH-1:0]  rdata [N_READ]
);

  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Next-state of the array: apply writes in ascending port order so the
  // highest-indexed port on a shared address is the one that sticks.
  // NOTE: mem_d is copied from mem_q before any conditional write; without
  // that default every unwritten entry would infer a latch.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < N_WRITE; w++) begin
      if (we[w] && !(ZERO_REG && waddr[w] == '0)) begin
        mem_d[waddr[w]] = wdata[w];
      end
    end
  end

  // Storage register with asynchronous clear.
  // NOTE: this array is deliberately reset; reads must return zero right
  // after reset, so the clear cannot be dropped as it could for a plain RAM.
  // NOTE: state is updated with <= only, so every read in this edge sees the
  // pre-edge contents regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read with optional same-cycle forwarding and zero register.
  always_comb begin
    for (int r = 0; r < N_READ; r++) begin
      rdata[r] = mem_q[raddr[r]];
      if (BYPASS && !reset) begin
        for (int w = 0; w < N_WRITE; w++) begin
          if (we[w] && waddr[w] == raddr[r]) begin
            rdata[r] = wdata[w];
          end
        end
      end
      if (ZERO_REG && raddr[r] == '0) begin
        rdata[r] = '0;
      end
    end
  end

endmodule : regbank

// File: rtl/operand_regfile.sv
// Operand register file behind the source stage: architectural file (ARF)
// plus physical/rename file (PRF), combinational paired reads, writeback
// into the PRF, commit-time copy from PRF to ARF, and per-entry
// "value produced" tracking.
// Build option: define OPERAND_BYPASS_EN to forward same-cycle writeback
// data to PRF reads/commits and same-cycle commit data to ARF reads.
module operand_regfile #(
  parameter int AREG_READ_PORTS = source_pkg::AREG_READ_PORTS,
  parameter int AREG_NUM        = source_pkg::AREG_NUM,
  parameter int PREG_NUM        = source_pkg::PREG_NUM,
  parameter int WB_PORTS        = source_pkg::WB_PORTS,
  parameter int COMMIT_PORTS    = source_pkg::COMMIT_PORTS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [4:0]                  src1     [AREG_READ_PORTS],
  input  logic [4:0]                  src2     [AREG_READ_PORTS],
  input  logic [$clog2(PREG_NUM)-1:0] psrc1    [AREG_READ_PORTS],
  input  logic [$clog2(PREG_NUM)-1:0] psrc2    [AREG_READ_PORTS],
  output logic [63:0]                 arf1     [AREG_READ_PORTS],
  output logic [63:0]                 arf2     [AREG_READ_PORTS],
  output logic [63:0]                 prf1     [AREG_READ_PORTS],
  output logic [63:0]                 prf2     [AREG_READ_PORTS],
  input  logic [WB_PORTS-1:0]         wb_valid,
  input  logic [$clog2(PREG_NUM)-1:0] wb_pdst  [WB_PORTS],
  input  logic [63:0]                 wb_data  [WB_PORTS],
  input  logic [COMMIT_PORTS-1:0]     cm_valid,
  input  logic [$clog2(PREG_NUM)-1:0] cm_psrc  [COMMIT_PORTS],
  input  logic [4:0]                  cm_dst   [COMMIT_PORTS],
  input  logic                        flush,
  output logic [PREG_NUM-1:0]         prf_written
);

  localparam int PW     = $clog2(PREG_NUM);
  localparam int R      = AREG_READ_PORTS;
  localparam int PRF_RD = 2 * R + COMMIT_PORTS;  // source reads + commit reads
  localparam int ARF_RD = 2 * R;

`ifdef OPERAND_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [PW-1:0]       prf_raddr [PRF_RD];
  logic [63:0]         prf_rdata [PRF_RD];
  logic [4:0]          arf_raddr [ARF_RD];
  logic [63:0]         arf_rdata [ARF_RD];
  logic [COMMIT_PORTS-1:0] arf_we;
  logic [63:0]         arf_wdata [COMMIT_PORTS];
  logic [PREG_NUM-1:0] written_d;
  logic [PREG_NUM-1:0] written_q;

  // Read-address fan-in: source pairs first, then one PRF read per commit port.
  always_comb begin
    for (int i = 0; i < R; i++) begin
      prf_raddr[i]     = psrc1[i];
      prf_raddr[R + i] = psrc2[i];
      arf_raddr[i]     = src1[i];
      arf_raddr[R + i] = src2[i];
    end
    for (int c = 0; c < COMMIT_PORTS; c++) begin
      prf_raddr[2 * R + c] = cm_psrc[c];
    end
  end

  // Read-data fan-out to the source-stage operand pairs.
  always_comb begin
    for (int i = 0; i < R; i++) begin
      prf1[i] = prf_rdata[i];
      prf2[i] = prf_rdata[R + i];
      arf1[i] = arf_rdata[i];
      arf2[i] = arf_rdata[R + i];
    end
  end

  // Commit writes: retiring PRF value into its ARF destination, x0 excluded.
  always_comb begin
    for (int c = 0; c < COMMIT_PORTS; c++) begin
      arf_we[c]    = cm_valid[c] && (cm_dst[c] != '0);
      arf_wdata[c] = prf_rdata[2 * R + c];
    end
  end

  regbank #(
    .DEPTH    (PREG_NUM),
    .WIDTH    (64),
    .N_READ   (PRF_RD),
    .N_WRITE  (WB_PORTS),
    .ZERO_REG (1'b0),
    .BYPASS   (BYPASS_EN)
  ) u_prf (
    .clk   (clk),
    .reset (reset),
    .we    (wb_valid),
    .waddr (wb_pdst),
    .wdata (wb_data),
    .raddr (prf_raddr),
    .rdata (prf_rdata)
  );

  regbank #(
    .DEPTH    (AREG_NUM),
    .WIDTH    (64),
    .N_READ   (ARF_RD),
    .N_WRITE  (COMMIT_PORTS),
    .ZERO_REG (1'b1),
    .BYPASS   (BYPASS_EN)
  ) u_arf (
    .clk   (clk),
    .reset (reset),
    .we    (arf_we),
    .waddr (cm_dst),
    .wdata (arf_wdata),
    .raddr (arf_raddr),
    .rdata (arf_rdata)
  );

  // Produced-value flags: commit frees, writeback (reallocation) sets after
  // that, and flush overrides both.
  always_comb begin
    written_d = written_q;
    for (int c = 0; c < COMMIT_PORTS; c++) begin
      if (cm_valid[c] && cm_dst[c] != '0) begin
        written_d[cm_psrc[c]] = 1'b0;
      end
    end
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k]) begin
        written_d[wb_pdst[k]] = 1'b1;
      end
    end
    if (flush) begin
      written_d = '0;
    end
  end

  // Produced-value flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written_q <= '0;
    end else begin
      written_q <= written_d;
    end
  end

  assign prf_written = written_q;

  function automatic logic wb_hit(input logic [PW-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k] && wb_pdst[k] == idx) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Protocol checks: duplicate writeback targets, and commits of entries that
  // hold no produced value (or that race a writeback without forwarding).
  always @(posedge clk) begin
    if (!reset) begin
      for (int a = 0; a < WB_PORTS; a++) begin
        for (int b = a + 1; b < WB_PORTS; b++) begin
          assert (!(wb_valid[a] && wb_valid[b] && wb_pdst[a] == wb_pdst[b]));
        end
      end
      for (int c = 0; c < COMMIT_PORTS; c++) begin
        if (cm_valid[c]) begin
          if (BYPASS_EN) begin
            assert (written_q[cm_psrc[c]] || wb_hit(cm_psrc[c]));
          end else begin
            assert (written_q[cm_psrc[c]] && !wb_hit(cm_psrc[c]));
          end
        end
      end
    end
  end

endmodule : operand_regfile
